// File: rtl/mod_reduce_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_reduce_seq_if
//  Description : Operand/result handshake bundle for mod_reduce_seq.
//                Operand side : in_valid, in_ready, Din, Q (5-bit signed)
//                Result side  : out_valid, out_ready, Dout, Quot, Err
//                slave modport is the reducer, master modport its user.
//  Revision    : 1.0  initial release
// ============================================================================
interface mod_reduce_seq_if #(
    parameter int DW = 10,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] Din;
    logic [4:0]    Q;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] Dout;
    logic [DW-1:0] Quot;
    logic          Err;

    modport slave (
        input  in_valid, Din, Q, out_ready,
        output in_ready, out_valid, Dout, Quot, Err
    );

    modport master (
        output in_valid, Din, Q, out_ready,
        input  in_ready, out_valid, Dout, Quot, Err
    );
endinterface
`default_nettype wire

// File: rtl/mod_reduce_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mod_reduce_seq
//  Description : Sequential restoring divider that reduces an unsigned DW-bit
//                operand modulo a small signed modulus Q (legal 1..15),
//                producing the canonical residue and the quotient.
//  Ports       : clk        clock (rising edge)
//                rst        synchronous active-high reset
//                bus.in_valid/in_ready  operand handshake (Din, Q)
//                bus.out_valid/out_ready result handshake (Dout, Quot, Err)
//                bus.Err    set when the accepted Q was <= 0
//  Revision    : 1.0  initial release
// ============================================================================
module mod_reduce_seq #(
    parameter int DW = 10,
    parameter int RW = 4
) (
    input  wire               clk,
    input  wire               rst,
    mod_reduce_seq_if.slave   bus
);

    localparam int              c_CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DW - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [DW-1:0]   r_din;
    logic [4:0]      r_q;
    logic [4:0]      r_rem;
    logic [DW-1:0]   r_quot;
    logic [c_CW-1:0] r_cnt;
    logic            r_bad;

    logic            r_in_ready;
    logic            r_out_valid;
    logic [RW-1:0]   r_dout;
    logic [DW-1:0]   r_quot_out;
    logic            r_err;

    logic [4:0]      w_rp;
    logic            w_ge;
    logic [4:0]      w_rem_nx;
    logic            w_q_bad;

    // After every step R < Q <= 15, so the top remainder bit is always zero
    // on entry to the next shift; it is kept only to hold the 5-bit R'.
    logic            w_unused_rem_msb;
    assign w_unused_rem_msb = r_rem[4];

    // One restoring step: shift in the next dividend bit (MSB first), then
    // subtract Q if it fits. Unsigned compare is valid because Q is known
    // positive whenever this path is used.
    always_comb begin
        w_rp     = {r_rem[3:0], r_din[r_cnt]};
        w_ge     = (w_rp >= r_q);
        w_rem_nx = w_ge ? (w_rp - r_q) : w_rp;
    end

    // Signed Q <= 0: negative (sign bit) or zero.
    assign w_q_bad = bus.Q[4] | (bus.Q == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_din       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_cnt       <= '0;
            r_bad       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_quot_out  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_in_ready && bus.in_valid) begin
                        r_din      <= bus.Din;
                        r_q        <= bus.Q;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_cnt      <= c_CNT_LAST;
                        r_in_ready <= 1'b0;
                        r_bad      <= w_q_bad;
                        r_state    <= w_q_bad ? S_DONE : S_CALC;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end

                S_CALC: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= {r_quot[DW-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end

                S_DONE: begin
                    // Result registers load on the first DONE cycle and are
                    // re-loaded with identical values while backpressured.
                    if (r_out_valid && bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_dout      <= r_bad ? '0 : r_rem[RW-1:0];
                        r_quot_out  <= r_bad ? '0 : r_quot;
                        r_err       <= r_bad;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Dout      = r_dout;
    assign bus.Quot      = r_quot_out;
    assign bus.Err       = r_err;

endmodule
`default_nettype wire
